// File: rtl/imm_extend_unit.sv
// Immediate extension unit: zero/sign/upper/branch extension of a raw immediate,
// delivered through a 2-entry skid buffer with valid/ready handshakes on both sides.
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32   // must satisfy OUT_W >= IN_W + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [1:0]       occ
);

  // Handshake: a beat moves on a side when its valid and ready are both 1 at a
  // rising clk edge; valid never waits on ready, and in_ready uses only state (and rst).

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HALF  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state;
  logic [OUT_W-1:0] main_data;
  logic [1:0]       main_mode;
  logic [OUT_W-1:0] skid_data;
  logic [1:0]       skid_mode;
  logic [OUT_W-1:0] ext_data;
  logic             in_fire;
  logic             out_fire;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                              input logic [1:0]      mode);
    logic [OUT_W-1:0] sx;
    logic [OUT_W-1:0] res;
    sx  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    res = '0;
    case (mode)
      2'b00:   res = {{(OUT_W-IN_W){1'b0}}, imm};
      2'b01:   res = sx;
      2'b10:   res = {imm, {(OUT_W-IN_W){1'b0}}};
      default: res = {sx[OUT_W-3:0], 2'b00};
    endcase
    return res;
  endfunction

  assign ext_data  = extend(in_imm, in_mode);
  assign in_ready  = (state != FULL) && !rst;
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = main_data;
  assign out_mode  = main_mode;
  // The state encoding is the occupancy, so occ doubles as the FSM state view.
  assign occ       = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_mode <= 2'b00;
      skid_data <= '0;
      skid_mode <= 2'b00;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data <= ext_data;
            main_mode <= in_mode;
            state     <= HALF;
          end
        end
        HALF: begin
          if (in_fire && out_fire) begin
            main_data <= ext_data;
            main_mode <= in_mode;
          end else if (in_fire) begin
            skid_data <= ext_data;
            skid_mode <= in_mode;
            state     <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data <= skid_data;
            main_mode <= skid_mode;
            state     <= HALF;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 Parameter IN_W, default 16, immediate input width in bits.
REQ-002 Parameter OUT_W, default 32, extended output width in bits; the block SHALL only be legal with OUT_W >= IN_W+2.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  the producer presents an immediate.
REQ-006 in_ready  output  1  the block can accept; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-007 in_imm  input  IN_W  raw immediate.
REQ-008 in_mode  input  2  extension mode: 00 zero, 01 sign, 10 upper, 11 branch.
REQ-009 out_valid  output  1  out_data and out_mode are valid.
REQ-010 out_ready  input  1  the consumer takes the data; a transfer occurs when out_valid && out_ready at a rising edge.
REQ-011 out_data  output  OUT_W  extended result.
REQ-012 out_mode  output  2  mode tag carried with the result.
REQ-013 occ  output  2  buffer occupancy, 0..2.

Function
REQ-014 Mode 00 SHALL output {(OUT_W-IN_W) zeros, in_imm}.
REQ-015 Mode 01 SHALL output {(OUT_W-IN_W) copies of in_imm[IN_W-1], in_imm}.
REQ-016 Mode 10 SHALL output in_imm placed at bits [OUT_W-1:OUT_W-IN_W], with all lower bits zero.
REQ-017 Mode 11 SHALL output the mode-01 result shifted left by 2, with the two LSBs zero and the two MSBs discarded.
REQ-018 The extension SHALL be computed from in_imm/in_mode at the accepting edge and stored as a result; later input changes SHALL NOT affect stored entries.
REQ-019 Storage SHALL be a 2-entry skid buffer made of a main register (drives out_*) and a skid register.
REQ-020 FSM states SHALL be EMPTY (occ=0), HALF (occ=1) and FULL (occ=2).
REQ-021 Outputs per state SHALL be:
- out_valid=0 in EMPTY, 1 otherwise.
- in_ready=1 in EMPTY and HALF, 0 in FULL.
REQ-022 In EMPTY, an input transfer SHALL load main and move to HALF.
REQ-023 In HALF, the transitions SHALL be:
- input only: load skid and go to FULL.
- output only: go to EMPTY.
- both: load main with the new result and stay in HALF.
REQ-024 In FULL, an output transfer SHALL copy skid into main and move to HALF; there is no input transfer because in_ready=0.
REQ-025 Latency from an accepting edge to out_valid SHALL be 1 cycle when the buffer is EMPTY.
REQ-026 Throughput SHALL be one transfer per cycle when out_ready is held at 1.
REQ-027 Results SHALL leave the block in acceptance order: no loss, duplication or reordering.
REQ-028 in_ready SHALL depend only on registered state, with no combinational path from out_ready.
REQ-029 While out_valid=1 and out_ready=0, out_data and out_mode SHALL be held stable.
REQ-030 in_valid asserted while in_ready=0 SHALL be ignored, and no state SHALL change from it.
REQ-031 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-032 While rst=1, the block SHALL immediately, without waiting for a clock edge, drive:
- state EMPTY, occ=0.
- out_valid=0, out_data=0, out_mode=00.
- skid register=0, in_ready=0.
REQ-033 in_ready SHALL return to 1 in the first cycle after rst deasserts.
REQ-034 Reset asserted mid-operation, including in FULL, SHALL discard all buffered entries, with no partial transfer completing on that edge.

Verification
REQ-035 Mode sweep with IN_W=16, OUT_W=32, in_imm=0x8001 and out_ready=1 SHALL produce:
- mode 00 -> 0x00008001.
- mode 01 -> 0xFFFF8001.
- mode 10 -> 0x80010000.
- mode 11 -> 0xFFFE0004.
- each result appears 1 cycle after its accept.
REQ-036 Positive sign case: in_imm=0x7FFF in modes 01 and 11 SHALL produce 0x00007FFF and 0x0001FFFC.
REQ-037 Backpressure: with out_ready=0, sending 0x0001 then 0x0002 (mode 00) SHALL give:
- occ 1 then 2, in_ready=0 in FULL.
- out_data held at 0x00000001.
- after raising out_ready, 0x00000001 then 0x00000002 in consecutive cycles.
REQ-038 Streaming: in_valid=out_ready=1 for 8 cycles with incrementing in_imm SHALL give occ staying at 1 and 8 in-order outputs with no bubbles.
REQ-039 Reset in FULL: rst pulsed between clock edges SHALL drop out_valid and occ to 0 before the next edge, and no buffered data SHALL appear afterwards.
REQ-040 Stall input: in_valid=1 with in_imm changing while in FULL SHALL leave stored results unchanged.
